sa_feeder: RTL and testbench

SA_FEEDER -- requirements
Module: sa_feeder

---
 rtl/sa_pkg.sv | 21 ++
 rtl/sa_skew_line.sv | 51 +++++
 rtl/sa_feeder.sv | 165 ++++++++++++++++
 tb/tb_sa_feeder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array feeder, the array and its drain block.
// Default geometry plus the feeder's sequencing states.
package sa_pkg;

    localparam int N      = 4;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        SWAP   = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4
    } feeder_state_t;

    // One counter covers both the N weight beats and the 2N-1 drain cycles.
    function automatic int cnt_width(input int n);
        return $clog2(2 * n);
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Delay line of DEPTH register stages carrying {data, valid, switch} to one array row.
// Latency DEPTH cycles; no backpressure, shifts every cycle; sync reset clears every stage.
module sa_skew_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_switch,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_switch
);

    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_d;
    logic [DEPTH-1:0]             valid_q;
    logic [DEPTH-1:0]             valid_d;
    logic [DEPTH-1:0]             switch_q;
    logic [DEPTH-1:0]             switch_d;

    always_comb begin
        data_d[0]   = in_data;
        valid_d[0]  = in_valid;
        switch_d[0] = in_switch;
        for (int i = 1; i < DEPTH; i++) begin
            data_d[i]   = data_q[i-1];
            valid_d[i]  = valid_q[i-1];
            switch_d[i] = switch_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            valid_q  <= '0;
            switch_q <= '0;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            switch_q <= switch_d;
        end
    end

    assign out_data   = data_q[DEPTH-1];
    assign out_valid  = valid_q[DEPTH-1];
    assign out_switch = switch_q[DEPTH-1];

endmodule

// File: rtl/sa_feeder.sv
// Sequences weight load, weight swap, skewed activation streaming and drain into an NxN array.
// Weights reach the top edge 1 cycle after acceptance, row r activations 1+r cycles after; ready-based backpressure.
module sa_feeder #(
    parameter int N      = sa_pkg::N,
    parameter int DATA_W = sa_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_reuse_w,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [N*DATA_W-1:0] w_data,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [N*DATA_W-1:0] a_data,
    input  logic                a_last,
    output logic [N*DATA_W-1:0] north_weight,
    output logic [N-1:0]        north_accept_w,
    output logic [N*DATA_W-1:0] west_input,
    output logic [N-1:0]        west_valid,
    output logic [N-1:0]        west_switch,
    output logic                busy,
    output logic                tile_done
);

    import sa_pkg::feeder_state_t;
    import sa_pkg::IDLE;
    import sa_pkg::LOAD_W;
    import sa_pkg::SWAP;
    import sa_pkg::STREAM;
    import sa_pkg::DRAIN;
    import sa_pkg::cnt_width;

    localparam int               CNT_W      = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(2 * N - 2);

    feeder_state_t       state_q;
    feeder_state_t       state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [N*DATA_W-1:0] north_weight_q;
    logic [N*DATA_W-1:0] north_weight_d;
    logic                north_accept_q;
    logic                north_accept_d;

    logic                w_fire;
    logic                head_valid;
    logic                head_switch;
    logic [N*DATA_W-1:0] head_data;

    always_comb begin
        state_d     = state_q;
        cmd_ready   = 1'b0;
        w_ready     = 1'b0;
        a_ready     = 1'b0;
        tile_done   = 1'b0;
        head_valid  = 1'b0;
        head_switch = 1'b0;
        head_data   = '0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = cmd_reuse_w ? STREAM : LOAD_W;
                end
            end
            LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && (cnt_q == LAST_BEAT)) begin
                    state_d = SWAP;
                end
            end
            SWAP: begin
                head_switch = 1'b1;
                state_d     = STREAM;
            end
            STREAM: begin
                a_ready = 1'b1;
                // A stalled cycle still advances the skew lines, as a zero bubble.
                if (a_valid) begin
                    head_valid = 1'b1;
                    head_data  = a_data;
                    if (a_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == LAST_DRAIN) begin
                    tile_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            cmd_ready   = 1'b0;
            w_ready     = 1'b0;
            a_ready     = 1'b0;
            tile_done   = 1'b0;
            head_valid  = 1'b0;
            head_switch = 1'b0;
            head_data   = '0;
        end
    end

    assign w_fire = w_valid & w_ready;

    // Restarting from zero on every state change lets LOAD_W and DRAIN share the counter.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (w_fire || (state_q == DRAIN)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        north_accept_d = w_fire;
        north_weight_d = w_fire ? w_data : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            north_weight_q <= '0;
            north_accept_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            north_weight_q <= north_weight_d;
            north_accept_q <= north_accept_d;
        end
    end

    assign north_weight   = north_weight_q;
    assign north_accept_w = {N{north_accept_q}};
    assign busy           = (state_q != IDLE) && !rst;

    for (genvar r = 0; r < N; r++) begin : g_row
        sa_skew_line #(
            .DEPTH  (r + 1),
            .DATA_W (DATA_W)
        ) u_skew (
            .clk        (clk),
            .rst        (rst),
            .in_data    (head_data[r*DATA_W +: DATA_W]),
            .in_valid   (head_valid),
            .in_switch  (head_switch),
            .out_data   (west_input[r*DATA_W +: DATA_W]),
            .out_valid  (west_valid[r]),
            .out_switch (west_switch[r])
        );
    end

endmodule

// File: tb/tb_sa_feeder.sv
// Bench for sa_feeder: per-tile schedule model predicts every output cycle by cycle.
`timescale 1ns/1ps
module tb_sa_feeder;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int W    = N * DW;
    localparam int MAXC = 160;
    localparam int MAXV = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready, cmd_reuse_w;
    logic         w_valid, w_ready;
    logic [W-1:0] w_data;
    logic         a_valid, a_ready, a_last;
    logic [W-1:0] a_data;
    logic [W-1:0] north_weight;
    logic [N-1:0] north_accept_w;
    logic [W-1:0] west_input;
    logic [N-1:0] west_valid, west_switch;
    logic         busy, tile_done;

    always #5 clk = ~clk;

    sa_feeder #(.N(N), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_reuse_w(cmd_reuse_w),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
        .north_weight(north_weight), .north_accept_w(north_accept_w),
        .west_input(west_input), .west_valid(west_valid), .west_switch(west_switch),
        .busy(busy), .tile_done(tile_done)
    );

    int total = 0;
    int bad   = 0;

    logic         wv_pat [MAXC];
    logic         av_pat [MAXC];
    logic [W-1:0] w_beats[N];
    logic [W-1:0] vecs   [MAXV];

    int           obs_done, obs_na;
    int           obs_sw [N];
    int           obs_fv [N];
    logic [DW-1:0] obs_fin[N];
    logic [N-1:0] obs_wv [MAXC];
    int           m_last;

    // Schedule model: from the host's valid patterns, derive when each beat/vector is
    // accepted, then place every expected output at its cycle.
    task automatic run_tile(input bit reuse, input int nvec);
        logic [W-1:0] hd[MAXC];
        logic         hv[MAXC], hs[MAXC], na[MAXC];
        logic [W-1:0] nw[MAXC];
        int tw, ss, L, done, stop, k, wk, ak, idx;
        logic         e_cr, e_busy, e_wr, e_ar, e_td;
        logic [N-1:0] e_na, e_wv, e_ws;
        logic [W-1:0] e_nw, e_wi;

        for (int t = 0; t < MAXC; t++) begin
            hd[t] = '0; hv[t] = 1'b0; hs[t] = 1'b0; na[t] = 1'b0; nw[t] = '0; obs_wv[t] = '0;
        end
        tw = 0;
        k  = 0;
        if (!reuse) begin
            for (int t = 1; t < MAXC - 1 && k < N; t++) begin
                if (wv_pat[t]) begin
                    na[t+1] = 1'b1;
                    nw[t+1] = w_beats[k];
                    k++;
                    tw = t;
                end
            end
            hs[tw+1] = 1'b1;
            ss = tw + 2;
        end else begin
            ss = 1;
        end
        k = 0;
        L = ss;
        for (int t = ss; t < MAXC && k < nvec; t++) begin
            if (av_pat[t]) begin
                hv[t] = 1'b1;
                hd[t] = vecs[k];
                k++;
                L = t;
            end
        end
        done   = L + 2 * N - 1;
        stop   = done + N + 1;
        m_last = L;

        obs_done = -1;
        obs_na   = 0;
        for (int r = 0; r < N; r++) begin
            obs_sw[r] = -1; obs_fv[r] = -1; obs_fin[r] = '0;
        end

        wk = 0;
        ak = 0;
        for (int t = 0; t <= stop; t++) begin
            cmd_valid   = (t == 0) ? 1'b1 : ((t <= done) ? 1'($urandom_range(0, 1)) : 1'b0);
            cmd_reuse_w = (t == 0) ? reuse : 1'($urandom_range(0, 1));
            w_valid     = (t <= done) ? wv_pat[t] : 1'b0;
            w_data      = (wk < N) ? w_beats[wk] : W'($urandom);
            a_valid     = (t <= done) ? av_pat[t] : 1'b0;
            a_data      = (ak < nvec) ? vecs[ak] : W'($urandom);
            a_last      = (ak == nvec - 1) ? 1'b1 : ((ak >= nvec) ? 1'($urandom_range(0, 1)) : 1'b0);

            e_cr   = (t == 0) || (t > done);
            e_busy = (t >= 1) && (t <= done);
            e_wr   = !reuse && (t >= 1) && (t <= tw);
            e_ar   = (t >= ss) && (t <= L);
            e_td   = (t == done);
            e_na   = na[t] ? '1 : '0;
            e_nw   = nw[t];
            e_wv   = '0;
            e_ws   = '0;
            e_wi   = '0;
            for (int r = 0; r < N; r++) begin
                idx = t - 1 - r;
                if (idx >= 0) begin
                    e_wv[r]           = hv[idx];
                    e_ws[r]           = hs[idx];
                    e_wi[r*DW +: DW]  = hd[idx][r*DW +: DW];
                end
            end

            @(negedge clk);
            total++; if (cmd_ready !== e_cr) begin bad++; $display("FAIL cmd_ready t=%0d got=%b exp=%b", t, cmd_ready, e_cr); end
            total++; if (busy !== e_busy) begin bad++; $display("FAIL busy t=%0d got=%b exp=%b", t, busy, e_busy); end
            total++; if (w_ready !== e_wr) begin bad++; $display("FAIL w_ready t=%0d got=%b exp=%b", t, w_ready, e_wr); end
            total++; if (a_ready !== e_ar) begin bad++; $display("FAIL a_ready t=%0d got=%b exp=%b", t, a_ready, e_ar); end
            total++; if (tile_done !== e_td) begin bad++; $display("FAIL tile_done t=%0d got=%b exp=%b", t, tile_done, e_td); end
            total++; if (north_accept_w !== e_na) begin bad++; $display("FAIL north_accept_w t=%0d got=%h exp=%h", t, north_accept_w, e_na); end
            total++; if (north_weight !== e_nw) begin bad++; $display("FAIL north_weight t=%0d got=%h exp=%h", t, north_weight, e_nw); end
            total++; if (west_valid !== e_wv) begin bad++; $display("FAIL west_valid t=%0d got=%b exp=%b", t, west_valid, e_wv); end
            total++; if (west_switch !== e_ws) begin bad++; $display("FAIL west_switch t=%0d got=%b exp=%b", t, west_switch, e_ws); end
            total++; if (west_input !== e_wi) begin bad++; $display("FAIL west_input t=%0d got=%h exp=%h", t, west_input, e_wi); end

            if (tile_done === 1'b1 && obs_done < 0) obs_done = t;
            if (north_accept_w !== '0) obs_na++;
            obs_wv[t] = west_valid;
            for (int r = 0; r < N; r++) begin
                if (west_switch[r] === 1'b1 && obs_sw[r] < 0) obs_sw[r] = t;
                if (west_valid[r] === 1'b1 && obs_fv[r] < 0) begin
                    obs_fv[r]  = t;
                    obs_fin[r] = west_input[r*DW +: DW];
                end
            end

            if (!reuse && t >= 1 && t <= tw && wv_pat[t]) wk++;
            if (t >= ss && t <= L && av_pat[t]) ak++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill_pats(input bit wrand, input bit arand);
        for (int t = 0; t < MAXC; t++) begin
            wv_pat[t] = (wrand && t < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
            av_pat[t] = (arand && t < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cmd_valid = 1'b1; cmd_reuse_w = 1'b0;
        w_valid = 1'b1; w_data = '1;
        a_valid = 1'b1; a_data = '1; a_last = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if ({w_ready, a_ready, tile_done} !== 3'b000) begin bad++; $display("FAIL rst_ready got=%b exp=000", {w_ready, a_ready, tile_done}); end
        total++; if (north_accept_w !== '0 || north_weight !== '0) begin bad++; $display("FAIL rst_north got=%h/%h exp=0", north_accept_w, north_weight); end
        total++; if (west_valid !== '0 || west_switch !== '0 || west_input !== '0) begin bad++; $display("FAIL rst_west got=%b/%b/%h exp=0", west_valid, west_switch, west_input); end
        @(posedge clk); #1;
        rst = 1'b0;
        cmd_valid = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_cmd_ready got=%b exp=1", cmd_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_new_weights;
        fill_pats(1'b0, 1'b0);
        for (int k = 0; k < N; k++) w_beats[k] = {N{8'(N - k)}};
        vecs[0] = {8'd4, 8'd3, 8'd2, 8'd1};
        vecs[1] = {8'd8, 8'd7, 8'd6, 8'd5};
        run_tile(1'b0, 2);
        for (int r = 0; r < N; r++) begin
            total++; if (obs_sw[r] !== 6 + r) begin bad++; $display("FAIL nw_switch_cycle row=%0d got=%0d exp=%0d", r, obs_sw[r], 6 + r); end
            total++; if (obs_fv[r] !== 7 + r) begin bad++; $display("FAIL nw_first_valid row=%0d got=%0d exp=%0d", r, obs_fv[r], 7 + r); end
            total++; if (obs_fin[r] !== 8'(r + 1)) begin bad++; $display("FAIL nw_first_data row=%0d got=%0d exp=%0d", r, obs_fin[r], r + 1); end
        end
        total++; if (obs_done !== 14) begin bad++; $display("FAIL nw_done_cycle got=%0d exp=14", obs_done); end
        total++; if (obs_na !== 4) begin bad++; $display("FAIL nw_accept_pulses got=%0d exp=4", obs_na); end
    endtask

    task automatic test_reuse;
        fill_pats(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) vecs[k] = W'($urandom);
        run_tile(1'b1, 3);
        total++; if (obs_na !== 0) begin bad++; $display("FAIL reuse_accept_pulses got=%0d exp=0", obs_na); end
        for (int r = 0; r < N; r++) begin
            total++; if (obs_sw[r] !== -1) begin bad++; $display("FAIL reuse_switch row=%0d got=%0d exp=none", r, obs_sw[r]); end
        end
        total++; if (obs_fv[0] !== 2) begin bad++; $display("FAIL reuse_first_valid got=%0d exp=2", obs_fv[0]); end
        total++; if (obs_done !== 10) begin bad++; $display("FAIL reuse_done_cycle got=%0d exp=10", obs_done); end
    endtask

    task automatic test_bubble;
        logic [5:0] seen;
        fill_pats(1'b0, 1'b0);
        av_pat[0] = 1'b0; av_pat[3] = 1'b0; av_pat[4] = 1'b0;
        for (int k = 0; k < 4; k++) vecs[k] = W'($urandom) | W'(32'h01010101);
        run_tile(1'b1, 4);
        for (int r = 0; r < N; r++) begin
            for (int i = 0; i < 6; i++) seen[5-i] = obs_wv[2 + r + i][r];
            total++; if (seen !== 6'b110011) begin bad++; $display("FAIL bubble_gap row=%0d got=%b exp=110011", r, seen); end
        end
        total++; if (obs_done !== 13) begin bad++; $display("FAIL bubble_done_cycle got=%0d exp=13", obs_done); end
    endtask

    task automatic test_weight_stall;
        fill_pats(1'b0, 1'b0);
        for (int t = 0; t < MAXC; t++) wv_pat[t] = 1'(t % 2);
        for (int k = 0; k < N; k++) w_beats[k] = W'($urandom);
        vecs[0] = W'($urandom);
        run_tile(1'b0, 1);
        total++; if (obs_na !== 4) begin bad++; $display("FAIL stall_accept_pulses got=%0d exp=4", obs_na); end
        total++; if (obs_sw[0] !== 9) begin bad++; $display("FAIL stall_switch_cycle got=%0d exp=9", obs_sw[0]); end
    endtask

    task automatic test_single_vector;
        int exp_s[N];
        exp_s = '{-128, 127, 0, -1};
        fill_pats(1'b0, 1'b0);
        vecs[0] = {8'hFF, 8'h00, 8'h7F, 8'h80};
        run_tile(1'b1, 1);
        for (int r = 0; r < N; r++) begin
            total++; if (int'($signed(obs_fin[r])) !== exp_s[r]) begin bad++; $display("FAIL single_signed row=%0d got=%0d exp=%0d", r, $signed(obs_fin[r]), exp_s[r]); end
        end
        total++; if (obs_done !== 8) begin bad++; $display("FAIL single_done_cycle got=%0d exp=8", obs_done); end
    endtask

    task automatic test_reset_mid_stream;
        bit saw_done;
        cmd_valid = 1'b1; cmd_reuse_w = 1'b1; a_valid = 1'b0; w_valid = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0; a_valid = 1'b1; a_data = W'(32'h11223344); a_last = 1'b0;
        @(posedge clk); #1;
        a_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        total++; if (west_valid[0] !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid got=%b exp=1", west_valid[0]); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (west_valid !== '0) begin bad++; $display("FAIL midrst_west_valid got=%b exp=0000", west_valid); end
        total++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL midrst_idle got=%b%b exp=10", cmd_ready, busy); end
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (tile_done === 1'b1 || west_valid !== '0) saw_done = 1'b1;
        end
        total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL midrst_no_done got=%b exp=0", saw_done); end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        bit reuse;
        int nvec;
        for (int n = 0; n < 6; n++) begin
            reuse = 1'($urandom_range(0, 1));
            nvec  = $urandom_range(1, 5);
            fill_pats(1'b1, 1'b1);
            for (int k = 0; k < N; k++) w_beats[k] = W'($urandom);
            for (int k = 0; k < nvec; k++) vecs[k] = W'($urandom);
            run_tile(reuse, nvec);
            total++; if (obs_done !== m_last + 7) begin bad++; $display("FAIL rand_done_cycle tile=%0d got=%0d exp=%0d", n, obs_done, m_last + 7); end
        end
    endtask

    initial begin
        test_reset;
        test_new_weights;
        test_reuse;
        test_bubble;
        test_weight_stall;
        test_single_vector;
        test_reset_mid_stream;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
